mem_cycle_sequencer: RTL and testbench
======================================

# mem_cycle_sequencer

- Multicycle sequencer for the rv32 core. It drives the fetch → decode → memory → writeback cycle.
- It shares the single memory bus port between instruction fetch (address from PC) and load/store data access (address from ALU result).
- It consumes the decoded flags from the control logic unit and gates register-file and PC updates.
- It latches the decoder flags once per instruction, generates byte enables, and traps a bus that never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: maximum bus-wait cycles per request before the sequencer enters ERROR (legal range 1..2^CNT_W−1).
- CNT_W, 8: width of the bus-wait counter.

Ports:
- clk  in  1  single clock; everything updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- halt  in  1  stop request; sampled only in IDLE and WB.
- read_mem  in  1  decoder flag; valid in DECODE.
- write_mem  in  1  decoder flag; valid in DECODE.
- load_byte  in  1  decoder flag; valid in DECODE.
- store_byte  in  1  decoder flag; valid in DECODE.
- reg_write_en  in  1  decoder flag; valid in DECODE.
- addr_lsb  in  2  ALU result [1:0]; valid in DECODE.
- bus_ack  in  1  single-cycle completion pulse from memory.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write request.
- bus_addr_sel  out  1  0 = PC, 1 = ALU result.
- bus_be  out  4  byte-lane enables.
- inst_latch_en  out  1  load the instruction register.
- pc_en  out  1  advance PC.
- rf_we  out  1  gated register-file write enable.
- state  out  3  current state, for debug.
- bus_timeout  out  1  sticky error flag.

## Operation
State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, ERROR=5.

Reset:
- rst high → state IDLE, counter 0, all latched flags 0, bus_timeout 0.
- Every output is 0 during and immediately after reset.

Per-state behaviour:
- IDLE:
  - All outputs 0.
  - Next state is FETCH if !halt, else stays in IDLE.
- FETCH:
  - bus_req=1, bus_we=0, bus_addr_sel=0, bus_be=4'b1111.
  - On bus_ack: inst_latch_en=1 in the same cycle (combinational), then → DECODE.
- DECODE (exactly one cycle, no bus activity):
  - Register rd=read_mem, wr=write_mem, lb=load_byte, sb=store_byte, rwe=reg_write_en, lsb=addr_lsb.
  - If read_mem|write_mem → MEM; otherwise → WB.
  - If read_mem and write_mem are both set, write wins: MEM issues a write and WB performs no register write.
- MEM:
  - bus_req=1, bus_addr_sel=1, bus_we=wr.
  - If lb|sb: bus_be = 4'b0001 << lsb. Otherwise bus_be = 4'b1111 and lsb is ignored.
  - On bus_ack → WB.
- WB (one cycle):
  - pc_en=1.
  - rf_we = rwe & ~wr: the decoder raises reg_write_en for stores, and the sequencer masks it here.
  - Next state is IDLE if halt, else FETCH.
- ERROR:
  - All outputs 0 except bus_timeout=1 and state=5.
  - Left only through rst.

Bus-wait counter:
- Cleared on every entry to FETCH and MEM.
- Increments on each FETCH/MEM cycle that has no bus_ack.
- If the counter equals TIMEOUT−1 and bus_ack is low in that cycle → ERROR.
- bus_ack in that same cycle wins: the request completes normally and there is no error.

Bus signalling rules:
- bus_ack is ignored in IDLE, DECODE, WB and ERROR.
- bus_we, bus_addr_sel and bus_be are 0 whenever bus_req is 0.
- bus_req and its qualifiers stay stable until the acknowledging cycle.

## Timing
- All outputs are Moore outputs (decoded from the registered state and latched flags), except inst_latch_en, which is Mealy on bus_ack in FETCH.
- Minimum latency with immediate bus_ack:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, WB).
  - Load/store: 4 cycles (FETCH, DECODE, MEM, WB).
- Each bus wait cycle adds 1.
- A request that is never acknowledged holds bus_req for TIMEOUT cycles; ERROR is visible in the next cycle.
- pc_en and rf_we are single-cycle pulses, asserted in the same cycle.
- rst asserted mid-MEM (or in any state) → IDLE on the next edge. bus_req drops in that cycle and no pc_en/rf_we is issued.
- halt asserted during FETCH/DECODE/MEM has no effect until WB; the in-flight instruction always completes.

## Test plan
- Reset then ALU op: rst 2 cycles; set reg_write_en=1 in DECODE; ack on the first FETCH cycle → state trace 0,1,2,4,1; rf_we=1 and pc_en=1 in the WB cycle only.
- Store byte: write_mem=1, store_byte=1, reg_write_en=1, addr_lsb=2; MEM ack after 3 waits → bus_we=1, bus_be=4'b0100, bus_addr_sel=1 for 4 cycles; rf_we=0 in WB.
- Load word: read_mem=1, addr_lsb=3 → bus_be=4'b1111, bus_we=0; rf_we=1 in WB.
- Timeout with TIMEOUT=4: no ack in FETCH → bus_req high for 4 cycles, then state=5, bus_timeout=1; stays there until rst. A second run with ack on the 4th cycle → DECODE, no error.
- Halt: halt=1 raised during MEM → instruction completes, WB→IDLE, outputs 0. halt=0 → FETCH next cycle.
- Reset mid-MEM: rst during a MEM wait → next cycle state=0, bus_req=0, no pc_en; bus_ack after reset is ignored.

Source files
------------

// File: rtl/mem_cycle_sequencer.sv
// Multicycle fetch/decode/memory/writeback sequencer for the rv32 core.
// Shares one memory bus port between instruction fetch (PC) and data access
// (ALU result), latches decoder flags once per instruction, produces byte
// lane enables and traps a bus that never acknowledges.
module mem_cycle_sequencer #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       halt_i,
   input  logic       read_mem_i,
   input  logic       write_mem_i,
   input  logic       load_byte_i,
   input  logic       store_byte_i,
   input  logic       reg_write_en_i,
   input  logic [1:0] addr_lsb_i,
   input  logic       bus_ack_i,
   output logic       bus_req_o,
   output logic       bus_we_o,
   output logic       bus_addr_sel_o,
   output logic [3:0] bus_be_o,
   output logic       inst_latch_en_o,
   output logic       pc_en_o,
   output logic       rf_we_o,
   output logic [2:0] state_o,
   output logic       bus_timeout_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      ERROR  = 3'd5
   } seqState_t;

   // Last wait-counter value a request may reach before it is declared dead.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   seqState_t        state_q, state_d;
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
   logic             wr_q, wr_d;
   logic             lb_q, lb_d;
   logic             sb_q, sb_d;
   logic             rwe_q, rwe_d;
   logic [1:0]       lsb_q, lsb_d;

   // State, bus-wait counter and latched decoder flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         wr_q      <= 1'b0;
         lb_q      <= 1'b0;
         sb_q      <= 1'b0;
         rwe_q     <= 1'b0;
         lsb_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         wr_q      <= wr_d;
         lb_q      <= lb_d;
         sb_q      <= sb_d;
         rwe_q     <= rwe_d;
         lsb_q     <= lsb_d;
      end
   end

   // Next state, wait counting and once-per-instruction flag capture.
   // The read flag only steers DECODE toward MEM; a write always wins, so
   // only the write flag needs to be remembered for the bus direction.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      wr_d      = wr_q;
      lb_d      = lb_q;
      sb_d      = sb_q;
      rwe_d     = rwe_q;
      lsb_d     = lsb_q;
      case (state_q)
         IDLE: begin
            if (!halt_i) begin
               state_d   = FETCH;
               waitCnt_d = '0;
            end
         end
         FETCH, MEM: begin
            if (bus_ack_i) begin
               state_d = (state_q == FETCH) ? DECODE : WB;
            end else if (waitCnt_q == LAST_WAIT) begin
               state_d = ERROR;
            end else begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end
         DECODE: begin
            wr_d  = write_mem_i;
            lb_d  = load_byte_i;
            sb_d  = store_byte_i;
            rwe_d = reg_write_en_i;
            lsb_d = addr_lsb_i;
            if (read_mem_i || write_mem_i) begin
               state_d   = MEM;
               waitCnt_d = '0;
            end else begin
               state_d = WB;
            end
         end
         WB: begin
            if (halt_i) begin
               state_d = IDLE;
            end else begin
               state_d   = FETCH;
               waitCnt_d = '0;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs from the registered state and flags; inst_latch_en is the
   // one Mealy output so the instruction register captures on the ack cycle.
   // Everything is forced low while reset is held so nothing escapes mid-reset.
   always_comb begin
      bus_req_o       = 1'b0;
      bus_we_o        = 1'b0;
      bus_addr_sel_o  = 1'b0;
      bus_be_o        = 4'b0000;
      inst_latch_en_o = 1'b0;
      pc_en_o         = 1'b0;
      rf_we_o         = 1'b0;
      state_o         = 3'd0;
      bus_timeout_o   = 1'b0;
      if (!rst_i) begin
         state_o = state_q;
         case (state_q)
            FETCH: begin
               bus_req_o       = 1'b1;
               bus_be_o        = 4'b1111;
               inst_latch_en_o = bus_ack_i;
            end
            MEM: begin
               bus_req_o      = 1'b1;
               bus_addr_sel_o = 1'b1;
               bus_we_o       = wr_q;
               bus_be_o       = (lb_q || sb_q) ? (4'b0001 << lsb_q) : 4'b1111;
            end
            WB: begin
               pc_en_o = 1'b1;
               rf_we_o = rwe_q & ~wr_q;
            end
            ERROR: begin
               bus_timeout_o = 1'b1;
            end
            default: begin
               bus_req_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Randomized self-checking bench for mem_cycle_sequencer. Each instruction is
// expanded into its expected per-cycle output trace (fetch waits, decode,
// optional memory waits, writeback, halt/idle) and compared cycle by cycle.
module tb_mem_cycle_sequencer;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst, halt, rdIn, wrIn, lbIn, sbIn, rweIn, ack;
   logic [1:0] lsbIn;
   logic busReq, busWe, busSel, latchEn, pcEn, rfWe, timeoutFlag;
   logic [3:0] busBe;
   logic [2:0] stateOut;

   int total = 0;
   int bad   = 0;

   mem_cycle_sequencer #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .halt_i(halt),
      .read_mem_i(rdIn), .write_mem_i(wrIn), .load_byte_i(lbIn),
      .store_byte_i(sbIn), .reg_write_en_i(rweIn), .addr_lsb_i(lsbIn),
      .bus_ack_i(ack), .bus_req_o(busReq), .bus_we_o(busWe),
      .bus_addr_sel_o(busSel), .bus_be_o(busBe), .inst_latch_en_o(latchEn),
      .pc_en_o(pcEn), .rf_we_o(rfWe), .state_o(stateOut),
      .bus_timeout_o(timeoutFlag)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Packs an expected output set into one comparable vector.
   function automatic logic [13:0] vec(input logic [2:0] st, input logic req,
         input logic we, input logic sel, input logic [3:0] be,
         input logic lat, input logic pc, input logic rf, input logic to);
      return {st, req, we, sel, be, lat, pc, rf, to};
   endfunction

   function automatic logic [13:0] outVec();
      return {stateOut, busReq, busWe, busSel, busBe, latchEn, pcEn, rfWe, timeoutFlag};
   endfunction

   task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (state %0d vs %0d)",
                  tag, got, exp, got[13:11], exp[13:11]);
      end
   endtask

   // Drives one cycle of inputs at the falling edge and lets them settle.
   task automatic applyStimulus(input logic r, input logic h, input logic rd,
         input logic wr, input logic lb, input logic sb, input logic rwe,
         input logic [1:0] lsb, input logic a);
      @(negedge clk);
      rst = r; halt = h; rdIn = rd; wrIn = wr; lbIn = lb; sbIn = sb;
      rweIn = rwe; lsbIn = lsb; ack = a;
      #1;
   endtask

   // Same, with decoder flags randomized to show they only matter in DECODE.
   task automatic stepJunk(input logic r, input logic h, input logic a);
      applyStimulus(r, h, 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 2'($urandom), a);
   endtask

   // Two reset cycles then one IDLE cycle that releases into FETCH.
   task automatic resetSeq();
      for (int i = 0; i < 2; i++) begin
         stepJunk(1'b1, 1'($urandom), 1'($urandom));
         checkOutput("reset", outVec(), 14'h0);
      end
      stepJunk(1'b0, 1'b0, 1'($urandom));
      checkOutput("postReset", outVec(), 14'h0);
   endtask

   // A few cycles parked in ERROR, then recovery through reset.
   task automatic errorPhase();
      for (int i = 0; i < 3; i++) begin
         stepJunk(1'b0, 1'($urandom), 1'($urandom));
         checkOutput("error", outVec(), vec(3'd5, 0, 0, 0, 4'h0, 0, 0, 0, 1));
      end
      resetSeq();
   endtask

   // Runs one instruction starting at its first FETCH cycle and leaves the
   // DUT at the first FETCH cycle of the next one.
   task automatic runInstr(input logic rm, input logic wm, input logic lb,
         input logic sb, input logic rwe, input logic [1:0] lsb,
         input int fw, input int mw, input logic hlt, input int rstAt);
      logic done;
      logic a;
      logic [3:0] be;
      done = 1'b0;
      for (int i = 0; i < TO && !done; i++) begin
         a = (i == fw);
         stepJunk(1'b0, 1'($urandom), a);
         checkOutput("fetch", outVec(), vec(3'd1, 1, 0, 0, 4'hF, a, 0, 0, 0));
         done = a;
      end
      if (!done) begin
         errorPhase();
         return;
      end
      applyStimulus(1'b0, 1'($urandom), rm, wm, lb, sb, rwe, lsb, 1'($urandom));
      checkOutput("decode", outVec(), vec(3'd2, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      if (rm || wm) begin
         be = (lb || sb) ? 4'(1 << lsb) : 4'hF;
         done = 1'b0;
         for (int i = 0; i < TO && !done; i++) begin
            if (i == rstAt) begin
               stepJunk(1'b1, 1'($urandom), 1'($urandom));
               checkOutput("rstMem", outVec(), 14'h0);
               stepJunk(1'b0, 1'b1, 1'b1);
               checkOutput("afterRstMem", outVec(), 14'h0);
               stepJunk(1'b0, 1'b0, 1'b1);
               checkOutput("idleRelease", outVec(), 14'h0);
               return;
            end
            a = (i == mw);
            stepJunk(1'b0, 1'($urandom), a);
            checkOutput("mem", outVec(), vec(3'd3, 1, wm, 1, be, 0, 0, 0, 0));
            done = a;
         end
         if (!done) begin
            errorPhase();
            return;
         end
      end
      stepJunk(1'b0, hlt, 1'($urandom));
      checkOutput("wb", outVec(), vec(3'd4, 0, 0, 0, 4'h0, 0, 1, rwe & ~wm, 0));
      if (hlt) begin
         for (int i = 0; i < 1 + int'($urandom % 3); i++) begin
            stepJunk(1'b0, 1'b1, 1'($urandom));
            checkOutput("idleHalt", outVec(), 14'h0);
         end
         stepJunk(1'b0, 1'b0, 1'($urandom));
         checkOutput("idleGo", outVec(), 14'h0);
      end
   endtask

   // Directed scenarios followed by randomized instruction mixes.
   initial begin
      rst = 1'b1; halt = 1'b0; rdIn = 1'b0; wrIn = 1'b0; lbIn = 1'b0;
      sbIn = 1'b0; rweIn = 1'b0; lsbIn = 2'b00; ack = 1'b0;
      resetSeq();
      runInstr(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, -1);
      runInstr(0, 1, 0, 1, 1, 2'd2, 0, 3, 0, -1);
      runInstr(1, 0, 0, 0, 1, 2'd3, 1, 0, 0, -1);
      runInstr(1, 0, 1, 0, 1, 2'd1, 0, 2, 0, -1);
      runInstr(1, 1, 0, 0, 1, 2'd0, 0, 1, 0, -1);
      runInstr(0, 0, 0, 0, 1, 2'd0, 4, 0, 0, -1);
      runInstr(0, 0, 0, 0, 1, 2'd0, 3, 0, 0, -1);
      runInstr(1, 0, 0, 0, 0, 2'd0, 0, 4, 0, -1);
      runInstr(1, 0, 0, 0, 1, 2'd0, 0, 3, 1, -1);
      runInstr(0, 1, 0, 0, 0, 2'd0, 0, 5, 0, 2);
      for (int n = 0; n < 300; n++) begin
         runInstr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 2'($urandom),
                  ($urandom % 8 == 0) ? TO : int'($urandom % TO),
                  ($urandom % 8 == 0) ? TO : int'($urandom % TO),
                  1'($urandom % 4 == 0),
                  ($urandom % 10 == 0) ? int'($urandom % 3) : -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
